inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Read-only bridge between the fetch stage's SRAM-like instruction port and the AXI read channels (AR/R); it sits directly upstream of IF_stage.
- Accepts fetch requests, issues single-beat AXI reads in order, and returns each word to fetch as a one-cycle data_ok pulse.
- Supports a bounded number of outstanding reads so fetch can pipeline requests while earlier data returns.

Parameters:
MAX_OUTST, 2, maximum accepted-but-unreturned reads (1..7)
ARID_VAL, 4'd0, constant ARID driven on every read

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_sram_req  in  1  fetch request
inst_sram_wr  in  1  1 = write (unsupported; never accepted)
inst_sram_size  in  2  00 byte, 01 half, 10 word
inst_sram_addr  in  32  physical fetch address
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  one-cycle pulse: rdata valid
inst_sram_rdata  out  32  returned instruction word
arid  out  4  = ARID_VAL
araddr  out  32  latched request address
arlen  out  8  constant 0
arsize  out  3  {1'b0, latched size}
arburst  out  2  constant 2'b01
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  last beat (always 1 for arlen=0)
rvalid  in  1  R valid
rready  out  1  R ready
bus_err  out  1  sticky: a non-OKAY rresp was seen

Behaviour:
- Reset (async, reset=1): ar_state=AR_IDLE, arvalid=0, araddr=0, arsize=0, cnt=0, inst_sram_data_ok=0, inst_sram_rdata=0, bus_err=0.
- AR FSM states are AR_IDLE and AR_BUSY.
- addr_ok (combinational) = inst_sram_req & ~inst_sram_wr & ar_state==AR_IDLE & cnt<MAX_OUTST. It uses the registered cnt; a same-cycle R return does not free a slot.
- On addr_ok: latch araddr<=inst_sram_addr and arsize<={1'b0,inst_sram_size}; go to AR_BUSY, so arvalid=1 from the next cycle.
- AR_BUSY: hold arvalid, araddr and arsize stable until arvalid&arready, then return to AR_IDLE (arvalid=0 the next cycle). addr_ok is 0 throughout AR_BUSY.
- Peak acceptance rate is therefore 1 request per 2 cycles.
- rready = (cnt!=0). Beats arriving with cnt==0 are never accepted.
- R handshake (rvalid&rready&rlast): next cycle inst_sram_data_ok=1 for exactly one cycle and inst_sram_rdata<=rdata. rdata holds its value until the next handshake.
- R latency: AXI beat to data_ok is 1 cycle. Minimum latency from addr_ok to data_ok is 3 cycles (arready and rvalid both immediate).
- cnt: +1 on addr_ok, -1 on R handshake; both in the same cycle leave it unchanged.
  - cnt never exceeds MAX_OUTST and never goes below 0 (guaranteed by the rready gating).
- Ordering: data returns strictly in request order. rid is ignored because a single ARID is used.
- rresp!=2'b00 on a handshake sets bus_err=1, sticky until reset. Data is still delivered with data_ok.
- inst_sram_wr=1: addr_ok stays 0; the request is never accepted and no AXI activity results.
- Reset mid-operation: all state is cleared immediately. Outstanding reads are dropped; the system is expected to reset the interconnect together with this block.
- Fetch-side discards (cancel) are handled by the fetch stage. The bridge always returns every accepted read.

Decomposition:
- Shared package header: AXI encodings (BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_WORD=2'b10) and ARID_INST=4'd0, for reuse by the data-side bridge.
- One sub-module fits naturally: outst_counter (saturating up/down counter with width $clog2(MAX_OUTST+1), ports inc/dec/full/empty).

Test Plan:
- Single fetch at reset vector: req with addr=32'h1c000000, size=2'b10, arready=1, rvalid with rdata=32'h02800c0c one cycle after the AR handshake -> addr_ok at T0, arvalid at T1 with araddr=32'h1c000000 and arsize=3'b010, data_ok pulse at T3 with rdata=32'h02800c0c.
- AR backpressure: arready held 0 for 4 cycles -> arvalid and araddr stay stable for 4 cycles, addr_ok=0 throughout, exactly one AR handshake occurs.
- Outstanding limit (MAX_OUTST=2): req held high continuously, rvalid held 0 -> exactly two addr_ok pulses (addrs 0x1c000000, 0x1c000004), then addr_ok=0. After the first R beat, a third addr_ok occurs no earlier than 1 cycle after the handshake.
- In-order return: three requests with R data 0xA, 0xB, 0xC -> three data_ok pulses delivering 0xA, 0xB, 0xC in that order; cnt returns to 0.
- Error and write: rresp=2'b10 on a beat -> data_ok still pulses and bus_err=1 and stays high. req with wr=1 -> addr_ok=0 and arvalid stays 0.
- Async reset: assert reset in AR_BUSY with cnt=1 -> arvalid=0, data_ok=0, cnt=0 and bus_err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-channel encodings and the AR FSM state type.
// The data-side bridge reuses these encodings.
package inst_axi_rd_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [3:0] ARID_INST  = 4'd0;

    typedef enum logic {
        AR_IDLE,
        AR_BUSY
    } ar_state_e;

    // The SRAM size code maps directly onto AXI ARSIZE: 1, 2 or 4 bytes.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// Fetch-side SRAM-like port plus the AXI AR/R channels, bundled in one interface.
// slave is the bridge's view; master is the fetch stage and AXI fabric around it.
interface inst_axi_rd_bridge_if;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic        bus_err;

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output bus_err
    );

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  bus_err
    );

endinterface

// File: rtl/inst_axi_rd_bridge_outst_counter.sv
// Saturating up/down count of accepted-but-unreturned reads.
module inst_axi_rd_bridge_outst_counter #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned   CntW   = $clog2(MAX_OUTST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTST);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            w_inc;
    logic            w_dec;

    assign o_full  = (r_cnt >= MaxCnt);
    assign o_empty = (r_cnt == '0);
    assign w_inc   = i_inc & ~o_full;
    assign w_dec   = i_dec & ~o_empty;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_inc, w_dec})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch read bridge: SRAM-like requests to in-order single-beat AXI reads,
// each returned word presented as a one-cycle data_ok pulse.
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [3:0]  ARID_VAL  = ARID_INST
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_axi_rd_bridge_if.slave  io_bus
);

    ar_state_e   r_ar_state;
    ar_state_e   w_ar_state_nxt;
    logic [31:0] r_araddr;
    logic [2:0]  r_arsize;
    logic        r_data_ok;
    logic [31:0] r_rdata;
    logic        r_bus_err;

    logic        w_full;
    logic        w_empty;
    logic        w_addr_ok;
    logic        w_r_hs;
    logic        w_unused_rid;

    // Single ARID and in-order return make rid redundant.
    assign w_unused_rid = ^io_bus.rid;

    // Registered count only: a beat returning this cycle frees its slot next cycle.
    assign w_addr_ok = io_bus.inst_sram_req & ~io_bus.inst_sram_wr
                     & (r_ar_state == AR_IDLE) & ~w_full;
    assign w_r_hs    = io_bus.rvalid & ~w_empty & io_bus.rlast;

    inst_axi_rd_bridge_outst_counter #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst_counter (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_inc   (w_addr_ok),
        .i_dec   (w_r_hs),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_ar_state_nxt = r_ar_state;
        case (r_ar_state)
            AR_IDLE: if (w_addr_ok)      w_ar_state_nxt = AR_BUSY;
            AR_BUSY: if (io_bus.arready) w_ar_state_nxt = AR_IDLE;
            default:                     w_ar_state_nxt = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ar_state <= AR_IDLE;
            r_araddr   <= '0;
            r_arsize   <= '0;
        end else begin
            r_ar_state <= w_ar_state_nxt;
            if (w_addr_ok) begin
                r_araddr <= io_bus.inst_sram_addr;
                r_arsize <= axi_size(io_bus.inst_sram_size);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_data_ok <= w_r_hs;
            if (w_r_hs) begin
                r_rdata <= io_bus.rdata;
            end
            if (w_r_hs && (io_bus.rresp != RESP_OKAY)) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign io_bus.inst_sram_addr_ok = w_addr_ok;
    assign io_bus.inst_sram_data_ok = r_data_ok;
    assign io_bus.inst_sram_rdata   = r_rdata;

    assign io_bus.arid    = ARID_VAL;
    assign io_bus.araddr  = r_araddr;
    assign io_bus.arlen   = 8'd0;
    assign io_bus.arsize  = r_arsize;
    assign io_bus.arburst = BURST_INCR;
    assign io_bus.arlock  = 2'b00;
    assign io_bus.arcache = 4'b0000;
    assign io_bus.arprot  = 3'b000;
    assign io_bus.arvalid = (r_ar_state == AR_BUSY);

    assign io_bus.rready  = ~w_empty;
    assign io_bus.bus_err = r_bus_err;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Per-cycle vector table for inst_axi_rd_bridge with a returned-data scoreboard,
// plus a hand-written asynchronous-reset sequence.
module tb_inst_axi_rd_bridge;

    typedef struct {
        logic        req;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic        arrdy;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        eok;
        logic        earv;
        logic [31:0] eaddr;
        logic [2:0]  esz;
        logic        erdy;
        logic        edok;
        logic        eberr;
    } vec_t;

    logic        clk;
    logic        reset;
    int          total;
    int          bad;
    logic [31:0] sb[$];
    vec_t        tbl[$];

    inst_axi_rd_bridge_if bus ();

    inst_axi_rd_bridge #(
        .MAX_OUTST (2),
        .ARID_VAL  (4'd0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic req, input logic wr, input logic [1:0] sz, input logic [31:0] addr,
        input logic arrdy, input logic rv, input logic [31:0] rd, input logic [1:0] rr,
        input logic eok, input logic earv, input logic [31:0] eaddr, input logic [2:0] esz,
        input logic erdy, input logic edok, input logic eberr);
        vec_t v;
        v.req = req;   v.wr = wr;     v.sz = sz;       v.addr = addr;
        v.arrdy = arrdy; v.rv = rv;   v.rd = rd;       v.rr = rr;
        v.eok = eok;   v.earv = earv; v.eaddr = eaddr; v.esz = esz;
        v.erdy = erdy; v.edok = edok; v.eberr = eberr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check outputs 1 ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.inst_sram_req  = v.req;
        bus.inst_sram_wr   = v.wr;
        bus.inst_sram_size = v.sz;
        bus.inst_sram_addr = v.addr;
        bus.arready        = v.arrdy;
        bus.rvalid         = v.rv;
        bus.rdata          = v.rd;
        bus.rresp          = v.rr;
        #1;
        chk($sformatf("%s addr_ok", tag), 32'(bus.inst_sram_addr_ok), 32'(v.eok));
        chk($sformatf("%s arvalid", tag), 32'(bus.arvalid), 32'(v.earv));
        chk($sformatf("%s rready", tag), 32'(bus.rready), 32'(v.erdy));
        chk($sformatf("%s data_ok", tag), 32'(bus.inst_sram_data_ok), 32'(v.edok));
        chk($sformatf("%s bus_err", tag), 32'(bus.bus_err), 32'(v.eberr));
        if (v.earv) begin
            chk($sformatf("%s araddr", tag), bus.araddr, v.eaddr);
            chk($sformatf("%s arsize", tag), 32'(bus.arsize), 32'(v.esz));
        end
        if (bus.inst_sram_data_ok) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s sb_rdata: got %h expected no data", tag, bus.inst_sram_rdata);
            end else begin
                chk($sformatf("%s sb_rdata", tag), bus.inst_sram_rdata, sb.pop_front());
            end
        end
        if (v.rv && v.erdy) sb.push_back(v.rd);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.inst_sram_req  = 1'b0;
        bus.inst_sram_wr   = 1'b0;
        bus.inst_sram_size = 2'b10;
        bus.inst_sram_addr = '0;
        bus.arready        = 1'b0;
        bus.rid            = 4'd0;
        bus.rdata          = '0;
        bus.rresp          = 2'b00;
        bus.rlast          = 1'b1;
        bus.rvalid         = 1'b0;

        // Single fetch at the reset vector
        tbl.push_back(mk(1,0,2'b10,32'h1c000000, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,0,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,1,32'h1c000000,3'b010,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'h02800c0c,2'b00, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,1,0));
        // AR backpressure for four cycles
        tbl.push_back(mk(1,0,2'b10,32'h1c000040, 0,0,32'h0,2'b00, 1,0,32'h0,3'b000,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,2'b10,32'h1c000044, 0,0,32'h0,2'b00,
                             0,1,32'h1c000040,3'b010,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,1,32'h1c000040,3'b010,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'h11112222,2'b00, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,1,0));
        // Outstanding limit of two, slot freed one cycle after the R handshake
        tbl.push_back(mk(1,0,2'b10,32'h1c000000, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,0,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000004, 1,0,32'h0,2'b00, 0,1,32'h1c000000,3'b010,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000004, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000008, 1,0,32'h0,2'b00, 0,1,32'h1c000004,3'b010,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000008, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000008, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000008, 1,1,32'hc0de0000,2'b00, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000008, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,1,1,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'hc0de0004,2'b00, 0,1,32'h1c000008,3'b010,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'hc0de0008,2'b00, 0,0,32'h0,3'b000,1,1,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,1,0));
        // In-order return of A, B, C with overlapping accept and return
        tbl.push_back(mk(1,0,2'b10,32'h1c000100, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,0,0,0));
        tbl.push_back(mk(1,0,2'b01,32'h1c000104, 1,0,32'h0,2'b00, 0,1,32'h1c000100,3'b010,1,0,0));
        tbl.push_back(mk(1,0,2'b01,32'h1c000104, 1,1,32'h0000000a,2'b00, 1,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000108, 1,0,32'h0,2'b00, 0,1,32'h1c000104,3'b001,1,1,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000108, 1,1,32'h0000000b,2'b00, 1,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,1,32'h1c000108,3'b010,1,1,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'h0000000c,2'b00, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,1,0));
        // Write never accepted; error response still delivers data; stray beat ignored
        tbl.push_back(mk(1,1,2'b10,32'h1c000200, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,0,0));
        tbl.push_back(mk(1,1,2'b10,32'h1c000200, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,0,0));
        tbl.push_back(mk(1,0,2'b10,32'h1c000200, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,0,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,1,32'h1c000200,3'b010,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'hbad0bad0,2'b10, 0,0,32'h0,3'b000,1,0,0));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,1,1));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,0,1));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,1,32'hdeadbeef,2'b00, 0,0,32'h0,3'b000,0,0,1));
        tbl.push_back(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,0,1));

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst arvalid", 32'(bus.arvalid), 32'h0);
        chk("rst araddr", bus.araddr, 32'h0);
        chk("rst arsize", 32'(bus.arsize), 32'h0);
        chk("rst data_ok", 32'(bus.inst_sram_data_ok), 32'h0);
        chk("rst rdata", bus.inst_sram_rdata, 32'h0);
        chk("rst bus_err", 32'(bus.bus_err), 32'h0);
        chk("rst rready", 32'(bus.rready), 32'h0);
        chk("rst addr_ok", 32'(bus.inst_sram_addr_ok), 32'h0);
        chk("const arlen", 32'(bus.arlen), 32'h0);
        chk("const arburst", 32'(bus.arburst), 32'h1);
        chk("const arid", 32'(bus.arid), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // Reset asserted mid-cycle in AR_BUSY with one read outstanding and data_ok high
        apply(mk(1,0,2'b10,32'h1c000300, 1,0,32'h0,2'b00, 1,0,32'h0,3'b000,0,0,1), "r0");
        apply(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,1,32'h1c000300,3'b010,1,0,1), "r1");
        apply(mk(1,0,2'b10,32'h1c000304, 1,1,32'h12345678,2'b00, 1,0,32'h0,3'b000,1,0,1), "r2");
        apply(mk(0,0,2'b10,32'h0, 0,0,32'h0,2'b00, 0,1,32'h1c000304,3'b010,1,1,1), "r3");
        #2 reset = 1'b1;
        #1;
        chk("async arvalid", 32'(bus.arvalid), 32'h0);
        chk("async rready", 32'(bus.rready), 32'h0);
        chk("async data_ok", 32'(bus.inst_sram_data_ok), 32'h0);
        chk("async bus_err", 32'(bus.bus_err), 32'h0);
        chk("async araddr", bus.araddr, 32'h0);
        chk("async rdata", bus.inst_sram_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("sb drained", 32'(sb.size()), 32'h0);
        sb.delete();

        // Recovery: the reset-vector fetch again
        for (int i = 0; i < 4; i++) apply(tbl[i], $sformatf("rec%0d", i));
        apply(mk(0,0,2'b10,32'h0, 1,0,32'h0,2'b00, 0,0,32'h0,3'b000,0,0,0), "rec4");
        chk("sb final", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
